// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Read-side consumer for the CDC FIFO, entirely in the read clock domain.
//   Pops words from the FIFO head into a 2-entry skid buffer and presents them
//   as a registered valid/ready stream (1 word/cycle sustained, no combinational
//   path from out_ready to the FIFO pop). A flush sequence drains and discards
//   the buffer and the FIFO contents. Delivered and dropped words are counted.
//
// Ports
//   clock                in   read-domain clock
//   reset                in   synchronous, active-high reset
//   fifo_read_data       in   FIFO head word, valid whenever fifo_empty=0
//   fifo_empty           in   FIFO empty flag
//   fifo_read_increment  out  pop strobe (combinational)
//   out_data             out  stream data (skid entry 0), registered
//   out_valid            out  stream valid, registered
//   out_ready            in   stream ready from downstream
//   flush                in   start drain-and-discard (level, sampled each cycle)
//   flush_busy           out  1 while flushing
//   flush_done           out  one-cycle pulse when a flush completes
//   words_delivered      out  count of out_valid && out_ready handshakes
//   words_dropped        out  count of words discarded by flush
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    input  logic                   fifo_empty,
    output logic                   fifo_read_increment,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic                   flush_busy,
    output logic                   flush_done,
    output logic [COUNT_WIDTH-1:0] words_delivered,
    output logic [COUNT_WIDTH-1:0] words_dropped
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_count;
    logic [DATA_WIDTH-1:0]  r_entry0;
    logic [DATA_WIDTH-1:0]  r_entry1;
    logic                   r_out_valid;
    logic                   r_flush_busy;
    logic                   r_flush_done;
    logic [COUNT_WIDTH-1:0] r_delivered;
    logic [COUNT_WIDTH-1:0] r_dropped;

    logic                   w_deq;
    logic                   w_pop;
    logic [1:0]             w_slot;
    logic [1:0]             w_count_next;

    always_comb begin
        w_deq = (r_state == ST_RUN) && (r_count != 2'd0) && out_ready;

        // Pop decision depends only on registered count, never on out_ready,
        // so there is no combinational path out_ready -> FIFO.
        w_pop = 1'b0;
        if (!reset && !fifo_empty) begin
            if (r_state == ST_FLUSH) begin
                w_pop = 1'b1;
            end else if (!flush && (r_count != 2'd2)) begin
                w_pop = 1'b1;
            end
        end

        // Slot the popped word lands in, after a dequeue shifts entry1 down.
        w_slot = r_count - {1'b0, w_deq};

        w_count_next = '0;
        if (r_state == ST_RUN && !flush) begin
            w_count_next = r_count + {1'b0, w_pop} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_entry0     <= '0;
            r_entry1     <= '0;
            r_out_valid  <= 1'b0;
            r_flush_busy <= 1'b0;
            r_flush_done <= 1'b0;
            r_delivered  <= '0;
            r_dropped    <= '0;
        end else begin
            r_flush_done <= 1'b0;
            r_count      <= w_count_next;
            r_out_valid  <= (w_count_next != 2'd0);
            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        // A handshake in the transition cycle still counts as
                        // delivered; only the remaining buffered words drop.
                        r_state      <= ST_FLUSH;
                        r_flush_busy <= 1'b1;
                        r_delivered  <= r_delivered + COUNT_WIDTH'(w_deq);
                        r_dropped    <= r_dropped + COUNT_WIDTH'(w_slot);
                    end else begin
                        if (w_deq) begin
                            r_entry0    <= r_entry1;
                            r_delivered <= r_delivered + 1'b1;
                        end
                        if (w_pop) begin
                            if (w_slot == 2'd0) begin
                                r_entry0 <= fifo_read_data;
                            end else begin
                                r_entry1 <= fifo_read_data;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_pop) begin
                        r_dropped <= r_dropped + 1'b1;
                    end
                    if (fifo_empty) begin
                        r_state      <= ST_RUN;
                        r_flush_busy <= 1'b0;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_flush_busy <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read_increment = w_pop;
    assign out_data            = r_entry0;
    assign out_valid           = r_out_valid;
    assign flush_busy          = r_flush_busy;
    assign flush_done          = r_flush_done;
    assign words_delivered     = r_delivered;
    assign words_dropped       = r_dropped;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Self-checking bench for fifo_stream_reader. The FIFO is a queue in the
//   bench; a queue-based reference model tracks the buffered words, flush
//   state and counters.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          pop;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          ready;
    logic          flush;
    logic          busy;
    logic          done;
    logic [CW-1:0] deliv;
    logic [CW-1:0] drop;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock              (clk),
        .reset              (rst),
        .fifo_read_data     (fifo_data),
        .fifo_empty         (fifo_empty),
        .fifo_read_increment(pop),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (ready),
        .flush              (flush),
        .flush_busy         (busy),
        .flush_done         (done),
        .words_delivered    (deliv),
        .words_dropped      (drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side FIFO contents and reference model state.
    logic [DW-1:0] bq[$];
    logic [DW-1:0] m_skid[$];
    bit            m_flushing = 1'b0;
    bit            m_done     = 1'b0;
    bit            m_pop      = 1'b0;
    logic [CW-1:0] m_deliv    = '0;
    logic [CW-1:0] m_drop     = '0;
    logic          last_pop   = 1'b0;

    task automatic apply_fifo();
        fifo_empty = (bq.size() == 0);
        fifo_data  = fifo_empty ? DW'($urandom) : bq[0];
    endtask

    // Advance one clock with the current inputs, updating the reference model.
    task automatic tick();
        int deq;
        apply_fifo();
        #1;
        last_pop = pop;
        if (rst) begin
            m_pop      = 1'b0;
            m_skid.delete();
            m_flushing = 1'b0;
            m_done     = 1'b0;
            m_deliv    = '0;
            m_drop     = '0;
        end else if (!m_flushing) begin
            deq    = (m_skid.size() != 0 && ready) ? 1 : 0;
            m_pop  = !fifo_empty && !flush && (m_skid.size() < 2);
            m_done = 1'b0;
            if (flush) begin
                m_deliv    = m_deliv + CW'(deq);
                m_drop     = m_drop + CW'(m_skid.size() - deq);
                m_skid.delete();
                m_flushing = 1'b1;
            end else begin
                if (deq != 0) begin
                    void'(m_skid.pop_front());
                    m_deliv = m_deliv + 1'b1;
                end
                if (m_pop) m_skid.push_back(fifo_data);
            end
        end else begin
            m_pop  = !fifo_empty;
            if (m_pop) m_drop = m_drop + 1'b1;
            m_done = fifo_empty;
            if (fifo_empty) m_flushing = 1'b0;
        end
        if (m_pop) void'(bq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bq.delete();
        rst   = 1'b1;
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bq.delete();
        rst   = 1'b1;
        ready = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({last_pop, out_valid, out_data, busy, done, deliv, drop} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs cyc=%0d got pop=%b v=%b d=%h busy=%b done=%b dl=%h dr=%h exp all 0",
                         i, last_pop, out_valid, out_data, busy, done, deliv, drop);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({last_pop, out_valid, busy, done, deliv, drop} !== '0) begin
                n_errors++;
                $display("FAIL idle_empty cyc=%0d got pop=%b v=%b busy=%b done=%b dl=%h dr=%h exp all 0",
                         i, last_pop, out_valid, busy, done, deliv, drop);
            end
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] w[3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) bq.push_back(w[i]);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (last_pop !== (c < 3)) begin
                n_errors++;
                $display("FAIL stream_pop cyc=%0d got=%b exp=%b", c, last_pop, (c < 3));
            end
            n_checks++;
            if (out_valid !== (c < 3) || (c < 3 && out_data !== w[c])) begin
                n_errors++;
                $display("FAIL stream_data cyc=%0d got v=%b d=%h exp v=%b d=%h",
                         c + 1, out_valid, out_data, (c < 3), (c < 3) ? w[c] : 8'h00);
            end
        end
        n_checks++;
        if (deliv !== 16'd3) begin
            n_errors++;
            $display("FAIL stream_delivered got=%0d exp=3", deliv);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[3] = '{8'h11, 8'h22, 8'h33};
        int pops = 0;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) bq.push_back(w[i]);
        for (int c = 0; c < 4; c++) begin
            tick();
            pops += int'(last_pop);
        end
        n_checks++;
        if (pops != 2) begin
            n_errors++;
            $display("FAIL bp_pops got=%0d exp=2", pops);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_errors++;
            $display("FAIL bp_hold got v=%b d=%h exp v=1 d=11", out_valid, out_data);
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== w[k]) begin
                n_errors++;
                $display("FAIL bp_order k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, w[k]);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || deliv !== 16'd3) begin
            n_errors++;
            $display("FAIL bp_end got v=%b dl=%0d exp v=0 dl=3", out_valid, deliv);
        end
    endtask

    task automatic test_flush();
        int pops  = 0;
        int dones = 0;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 7; i++) bq.push_back(DW'(8'hA0 + i));
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
            n_errors++;
            $display("FAIL flush_pre got v=%b d=%h exp v=1 d=a0", out_valid, out_data);
        end
        flush = 1'b1;
        tick();
        n_checks++;
        if (last_pop !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0 || drop !== 16'd2) begin
            n_errors++;
            $display("FAIL flush_enter got pop=%b busy=%b v=%b dr=%0d exp pop=0 busy=1 v=0 dr=2",
                     last_pop, busy, out_valid, drop);
        end
        // flush held one extra cycle inside FLUSH: must have no effect
        for (int i = 0; i < 20; i++) begin
            tick();
            flush = 1'b0;
            pops  += int'(last_pop);
            dones += int'(done);
        end
        n_checks++;
        if (pops != 5 || dones != 1) begin
            n_errors++;
            $display("FAIL flush_drain got pops=%0d dones=%0d exp pops=5 dones=1", pops, dones);
        end
        n_checks++;
        if (drop !== 16'd7 || busy !== 1'b0 || deliv !== 16'd0) begin
            n_errors++;
            $display("FAIL flush_counts got dr=%0d busy=%b dl=%0d exp dr=7 busy=0 dl=0", drop, busy, deliv);
        end
        bq.push_back(8'h5A);
        ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_errors++;
            $display("FAIL flush_resume got v=%b d=%h exp v=1 d=5a", out_valid, out_data);
        end
        tick();
        n_checks++;
        if (deliv !== 16'd1) begin
            n_errors++;
            $display("FAIL flush_resume_deliv got=%0d exp=1", deliv);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) bq.push_back(DW'(8'hC0 + i));
        repeat (3) tick();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) bq.push_back(DW'(8'hD0 + i));
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b1 || deliv !== 16'd2) begin
            n_errors++;
            $display("FAIL rstmid_pre got v=%b dl=%0d exp v=1 dl=2", out_valid, deliv);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (last_pop !== 1'b0 || out_valid !== 1'b0 || deliv !== 16'd0 || drop !== 16'd0) begin
                n_errors++;
                $display("FAIL rstmid cyc=%0d got pop=%b v=%b dl=%0d dr=%0d exp all 0",
                         i, last_pop, out_valid, deliv, drop);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 70000 && m_deliv != 16'hFFFF; i++) begin
            if (bq.size() < 2) bq.push_back(DW'($urandom));
            tick();
        end
        n_checks++;
        if (m_deliv != 16'hFFFF || deliv !== 16'hFFFF || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_preload got dl=%h v=%b exp dl=ffff v=1", deliv, out_valid);
        end
        tick();
        ready = 1'b0;
        n_checks++;
        if (deliv !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_rollover got=%h exp=0000", deliv);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            ready = ($urandom_range(9) < 7);
            flush = ($urandom_range(39) == 0);
            rst   = ($urandom_range(299) == 0);
            if ($urandom_range(9) < 6 && bq.size() < 8) bq.push_back(DW'($urandom));
            tick();
            n_checks++;
            if (last_pop !== m_pop) begin
                n_errors++;
                $display("FAIL rand_pop cyc=%0d got=%b exp=%b", i, last_pop, m_pop);
            end
            n_checks++;
            if (out_valid !== (m_skid.size() != 0)) begin
                n_errors++;
                $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, (m_skid.size() != 0));
            end
            if (m_skid.size() != 0) begin
                n_checks++;
                if (out_data !== m_skid[0]) begin
                    n_errors++;
                    $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, m_skid[0]);
                end
            end
            n_checks++;
            if (busy !== m_flushing || done !== m_done) begin
                n_errors++;
                $display("FAIL rand_flush cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                         i, busy, done, m_flushing, m_done);
            end
            n_checks++;
            if (deliv !== m_deliv || drop !== m_drop) begin
                n_errors++;
                $display("FAIL rand_counts cyc=%0d got dl=%h dr=%h exp dl=%h dr=%h",
                         i, deliv, drop, m_deliv, m_drop);
            end
        end
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        flush = 1'b0;
        apply_fifo();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
